// File: rtl/fixed_matmul_acc.sv
// rtl/fixed_matmul_acc.sv - tiled fixed-point A*B^T accumulator with round/saturate output stage
// Operand beats are joined, accumulated at full precision over a tile, then quantised once.
module fixed_matmul_acc #(
    parameter int IN1_WIDTH       = 8,
    parameter int IN1_FRAC_WIDTH  = 4,
    parameter int IN2_WIDTH       = 8,
    parameter int IN2_FRAC_WIDTH  = 4,
    parameter int OUT_WIDTH       = 8,
    parameter int OUT_FRAC_WIDTH  = 4,
    parameter int IN1_PARALLELISM = 2,
    parameter int IN2_PARALLELISM = 2,
    parameter int IN_SIZE         = 4,
    parameter int MAX_DEPTH       = 8,
    parameter int ROUND           = 1
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [IN1_WIDTH*IN1_PARALLELISM*IN_SIZE-1:0]      data_in1,
    input  logic                                              data_in1_valid,
    output logic                                              data_in1_ready,
    input  logic [IN2_WIDTH*IN2_PARALLELISM*IN_SIZE-1:0]      data_in2,
    input  logic                                              data_in2_valid,
    output logic                                              data_in2_ready,
    input  logic [$clog2(MAX_DEPTH+1)-1:0]                    depth_cfg,
    output logic [OUT_WIDTH*IN1_PARALLELISM*IN2_PARALLELISM-1:0] data_out,
    output logic                                              data_out_valid,
    input  logic                                              data_out_ready,
    output logic                                              data_out_ovf
);

    localparam int SHIFT  = IN1_FRAC_WIDTH + IN2_FRAC_WIDTH - OUT_FRAC_WIDTH;
    localparam int DW     = $clog2(MAX_DEPTH + 1);
    localparam int PROD_W = IN1_WIDTH + IN2_WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(IN_SIZE * MAX_DEPTH);
    localparam int LANES  = IN1_PARALLELISM * IN2_PARALLELISM;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [ACC_W:0] RND_C =
        (ROUND != 0 && SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;
    localparam logic signed [ACC_W:0] OUT_MAX =
        $signed((ACC_W+1)'((1 << (OUT_WIDTH - 1)) - 1));
    localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic {S_ACCUM = 1'b0, S_OUT = 1'b1} state_t;

    state_t                         state_q, state_d;
    logic [DW-1:0]                  cnt_q, cnt_d;
    logic [DW-1:0]                  depth_q, depth_d;
    logic [ACC_W-1:0]               acc_q [LANES];
    logic [ACC_W-1:0]               acc_d [LANES];
    logic [OUT_WIDTH*LANES-1:0]     out_q, out_d;
    logic                           ovf_q, ovf_d;

    logic                           beat_accept;
    logic                           tile_first;
    logic                           last_beat;
    logic [DW-1:0]                  cfg_eff;
    logic [DW-1:0]                  depth_tgt;
    logic [ACC_W-1:0]               beat_acc [LANES];
    logic [ACC_W-1:0]               lane_sum;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_W:0]          ext;
    logic signed [ACC_W:0]          rsum;
    logic signed [ACC_W:0]          shifted;
    logic [OUT_WIDTH*LANES-1:0]     q_vec;
    logic [LANES-1:0]               clip;

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACCUM: if (beat_accept && last_beat) state_d = S_OUT;
            S_OUT:   if (data_out_ready)           state_d = S_ACCUM;
            default: state_d = S_ACCUM;
        endcase
    end

    // FSM: outputs; readies are forced low while reset is held
    always_comb begin
        data_out_valid = (state_q == S_OUT);
        data_in1_ready = rst && (state_q == S_ACCUM) && data_in2_valid;
        data_in2_ready = rst && (state_q == S_ACCUM) && data_in1_valid;
        beat_accept    = (state_q == S_ACCUM) && data_in1_valid && data_in2_valid;
    end

    // Depth is clamped into [1, MAX_DEPTH] and only taken on the first beat of a tile
    always_comb begin
        tile_first = (cnt_q == '0);
        if (depth_cfg == '0) begin
            cfg_eff = DW'(1);
        end else if (depth_cfg > DW'(MAX_DEPTH)) begin
            cfg_eff = DW'(MAX_DEPTH);
        end else begin
            cfg_eff = depth_cfg;
        end
        depth_tgt = tile_first ? cfg_eff : depth_q;
        last_beat = ((cnt_q + DW'(1)) == depth_tgt);
    end

    // A first beat starts from zero, which is how accumulators are cleared per tile
    always_comb begin
        lane_sum = '0;
        prod     = '0;
        for (int l = 0; l < LANES; l++) begin
            beat_acc[l] = '0;
        end
        for (int i = 0; i < IN1_PARALLELISM; i++) begin
            for (int j = 0; j < IN2_PARALLELISM; j++) begin
                lane_sum = tile_first ? '0 : acc_q[i*IN2_PARALLELISM + j];
                for (int k = 0; k < IN_SIZE; k++) begin
                    prod = $signed(data_in1[(i*IN_SIZE + k)*IN1_WIDTH +: IN1_WIDTH])
                         * $signed(data_in2[(j*IN_SIZE + k)*IN2_WIDTH +: IN2_WIDTH]);
                    lane_sum = lane_sum + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
                end
                beat_acc[i*IN2_PARALLELISM + j] = lane_sum;
            end
        end
    end

    // One spare bit above the accumulator keeps the rounding add from wrapping
    always_comb begin
        ext     = '0;
        rsum    = '0;
        shifted = '0;
        q_vec   = '0;
        clip    = '0;
        for (int l = 0; l < LANES; l++) begin
            ext     = {beat_acc[l][ACC_W-1], beat_acc[l]};
            rsum    = ext + RND_C;
            shifted = rsum >>> SHIFT;
            if (shifted > OUT_MAX) begin
                q_vec[l*OUT_WIDTH +: OUT_WIDTH] = OUT_MAX[OUT_WIDTH-1:0];
                clip[l] = 1'b1;
            end else if (shifted < OUT_MIN) begin
                q_vec[l*OUT_WIDTH +: OUT_WIDTH] = OUT_MIN[OUT_WIDTH-1:0];
                clip[l] = 1'b1;
            end else begin
                q_vec[l*OUT_WIDTH +: OUT_WIDTH] = shifted[OUT_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        depth_d = depth_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        if (beat_accept) begin
            acc_d = beat_acc;
            if (tile_first) begin
                depth_d = cfg_eff;
            end
            if (last_beat) begin
                cnt_d = '0;
                out_d = q_vec;
                ovf_d = |clip;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            depth_q <= DW'(1);
            out_q   <= '0;
            ovf_q   <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            depth_q <= depth_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            acc_q   <= acc_d;
        end
    end

    assign data_out     = out_q;
    assign data_out_ovf = ovf_q;

endmodule

// File: tb/tb_fixed_matmul_acc.sv
// tb/tb_fixed_matmul_acc.sv - directed bench for fixed_matmul_acc, ROUND=1 and ROUND=0 instances
// An integer reference model runs alongside and is compared with both instances every cycle.
module tb_fixed_matmul_acc;

    logic        clk;
    logic        rst;
    logic [63:0] data_in1;
    logic [63:0] data_in2;
    logic        data_in1_valid;
    logic        data_in2_valid;
    logic [3:0]  depth_cfg;
    logic        data_out_ready;

    logic        rdy1_0, rdy2_0, valid_0, ovf_0;
    logic        rdy1_1, rdy2_1, valid_1, ovf_1;
    logic [31:0] out_0, out_1;

    int n_tests = 0;
    int n_fail  = 0;

    fixed_matmul_acc #(.ROUND(1)) dut0 (
        .clk(clk), .rst(rst),
        .data_in1(data_in1), .data_in1_valid(data_in1_valid), .data_in1_ready(rdy1_0),
        .data_in2(data_in2), .data_in2_valid(data_in2_valid), .data_in2_ready(rdy2_0),
        .depth_cfg(depth_cfg),
        .data_out(out_0), .data_out_valid(valid_0), .data_out_ready(data_out_ready),
        .data_out_ovf(ovf_0)
    );

    fixed_matmul_acc #(.ROUND(0)) dut1 (
        .clk(clk), .rst(rst),
        .data_in1(data_in1), .data_in1_valid(data_in1_valid), .data_in1_ready(rdy1_1),
        .data_in2(data_in2), .data_in2_valid(data_in2_valid), .data_in2_ready(rdy2_1),
        .depth_cfg(depth_cfg),
        .data_out(out_1), .data_out_valid(valid_1), .data_out_ready(data_out_ready),
        .data_out_ovf(ovf_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int el(input logic [63:0] v, input int e);
        byte b;
        b = v[e*8 +: 8];
        return b;
    endfunction

    function automatic int lane(input logic [31:0] v, input int l);
        logic [7:0] r;
        r = v[l*8 +: 8];
        return int'(r);
    endfunction

    function automatic logic [63:0] rep8(input logic [7:0] b);
        return {8{b}};
    endfunction

    // Floor of (acc + rounding) / 16, i.e. the value before clamping
    function automatic int scaled(input int acc, input bit rnd);
        int r;
        r = acc + (rnd ? 8 : 0);
        if (r >= 0) return r / 16;
        return -((-r + 15) / 16);
    endfunction

    function automatic int qval(input int acc, input bit rnd);
        int s;
        s = scaled(acc, rnd);
        if (s > 127)  return 127;
        if (s < -128) return -128;
        return s;
    endfunction

    function automatic bit qclip(input int acc, input bit rnd);
        int s;
        s = scaled(acc, rnd);
        return (s > 127) || (s < -128);
    endfunction

    // Reference model
    bit m_out   = 1'b0;
    int m_cnt   = 0;
    int m_depth = 1;
    int m_acc [4];
    int e0 [4];
    int e1 [4];
    bit ov0 = 1'b0;
    bit ov1 = 1'b0;

    initial begin
        foreach (m_acc[l]) begin
            m_acc[l] = 0; e0[l] = 0; e1[l] = 0;
        end
        forever begin
            @(posedge clk or negedge rst);
            if (rst !== 1'b1) begin
                m_out = 1'b0; m_cnt = 0; m_depth = 1;
                foreach (m_acc[l]) begin
                    m_acc[l] = 0; e0[l] = 0; e1[l] = 0;
                end
                ov0 = 1'b0; ov1 = 1'b0;
            end else if (!m_out) begin
                if (data_in1_valid && data_in2_valid) begin
                    if (m_cnt == 0) begin
                        m_depth = (depth_cfg == 0) ? 1 : ((depth_cfg > 8) ? 8 : int'(depth_cfg));
                        foreach (m_acc[l]) m_acc[l] = 0;
                    end
                    for (int i = 0; i < 2; i++)
                        for (int j = 0; j < 2; j++)
                            for (int k = 0; k < 4; k++)
                                m_acc[i*2+j] += el(data_in1, i*4+k) * el(data_in2, j*4+k);
                    m_cnt++;
                    if (m_cnt == m_depth) begin
                        m_out = 1'b1; m_cnt = 0; ov0 = 1'b0; ov1 = 1'b0;
                        for (int l = 0; l < 4; l++) begin
                            e0[l] = qval(m_acc[l], 1'b1);
                            e1[l] = qval(m_acc[l], 1'b0);
                            ov0 |= qclip(m_acc[l], 1'b1);
                            ov1 |= qclip(m_acc[l], 1'b0);
                        end
                    end
                end
            end else if (data_out_ready) begin
                m_out = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("valid_r1", valid_0, m_out);
            chk("valid_r0", valid_1, m_out);
            chk("in1_ready", rdy1_0, (rst === 1'b1) && !m_out && data_in2_valid);
            chk("in2_ready", rdy2_0, (rst === 1'b1) && !m_out && data_in1_valid);
            chk("in1_ready_r0", rdy1_1, (rst === 1'b1) && !m_out && data_in2_valid);
            if (m_out) begin
                for (int l = 0; l < 4; l++) begin
                    chk($sformatf("lane%0d_r1", l), lane(out_0, l), e0[l] & 255);
                    chk($sformatf("lane%0d_r0", l), lane(out_1, l), e1[l] & 255);
                end
                chk("ovf_r1", ovf_0, ov0);
                chk("ovf_r0", ovf_1, ov1);
            end
            if (rst !== 1'b1) begin
                chk("rst_out_r1", out_0, 0);
                chk("rst_out_r0", out_1, 0);
                chk("rst_ovf", ovf_0, 0);
            end
        end
    end

    task automatic send_tile(input int cfg_first, input int cfg_rest, input int n,
                             input logic [63:0] a, input logic [63:0] b, input bit done);
        for (int i = 0; i < n; i++) begin
            depth_cfg = (i == 0) ? 4'(cfg_first) : 4'(cfg_rest);
            data_in1 = a; data_in2 = b;
            data_in1_valid = 1'b1; data_in2_valid = 1'b1;
            @(posedge clk); #1;
            data_in1_valid = 1'b0; data_in2_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("beat%0d_valid", i), valid_0, (done && i == n - 1));
        end
    endtask

    task automatic lit_all(input logic [7:0] x0, input logic [7:0] x1,
                           input bit o0, input bit o1);
        chk("lit_r1", out_0, {4{x0}});
        chk("lit_r0", out_1, {4{x1}});
        chk("lit_ovf_r1", ovf_0, o0);
        chk("lit_ovf_r0", ovf_1, o1);
    endtask

    task automatic ack();
        data_out_ready = 1'b1;
        @(posedge clk); #1;
        data_out_ready = 1'b0;
    endtask

    logic [63:0] mix_a, mix_b;

    initial begin
        rst = 1'b0;
        data_in1 = rep8(8'h10); data_in2 = rep8(8'h10);
        data_in1_valid = 1'b1; data_in2_valid = 1'b1;
        depth_cfg = 4'd1; data_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", valid_0, 0);
        chk("reset_rdy1", rdy1_0, 0);
        chk("reset_rdy2", rdy2_0, 0);
        chk("reset_out", out_0, 0);
        @(posedge clk); #1;
        data_in1_valid = 1'b0; data_in2_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        send_tile(1, 1, 1, rep8(8'h10), rep8(8'h10), 1'b1);
        lit_all(8'h40, 8'h40, 1'b0, 1'b0);
        ack();

        send_tile(3, 3, 3, rep8(8'h10), rep8(8'h10), 1'b1);
        lit_all(8'h7F, 8'h7F, 1'b1, 1'b1);
        ack();

        send_tile(2, 2, 2, rep8(8'hF0), rep8(8'h10), 1'b1);
        lit_all(8'h80, 8'h80, 1'b0, 1'b0);
        ack();

        send_tile(1, 1, 1, rep8(8'h01), rep8(8'h02), 1'b1);
        lit_all(8'h01, 8'h00, 1'b0, 1'b0);
        data_in1 = rep8(8'h7F); data_in2 = rep8(8'h7F);
        data_in1_valid = 1'b1; data_in2_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_out", out_0, 32'h01010101);
            chk("hold_rdy1", rdy1_0, 0);
            chk("hold_rdy2", rdy2_0, 0);
        end
        data_in1_valid = 1'b0; data_in2_valid = 1'b0;
        ack();

        data_in1_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("half_rdy1", rdy1_0, 0);
            chk("half_rdy2", rdy2_0, 1);
            chk("half_valid", valid_0, 0);
        end
        data_in1_valid = 1'b0;
        send_tile(1, 1, 1, rep8(8'h10), rep8(8'h10), 1'b1);
        lit_all(8'h40, 8'h40, 1'b0, 1'b0);
        ack();

        send_tile(3, 3, 2, rep8(8'h10), rep8(8'h10), 1'b0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out", out_0, 0);
        chk("midrst_valid", valid_0, 0);
        chk("midrst_rdy", rdy1_0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        send_tile(1, 1, 1, rep8(8'h10), rep8(8'h10), 1'b1);
        lit_all(8'h40, 8'h40, 1'b0, 1'b0);
        ack();

        send_tile(0, 0, 1, rep8(8'h10), rep8(8'h10), 1'b1);
        lit_all(8'h40, 8'h40, 1'b0, 1'b0);
        ack();

        send_tile(15, 15, 8, rep8(8'h01), rep8(8'h02), 1'b1);
        lit_all(8'h04, 8'h04, 1'b0, 1'b0);
        ack();

        send_tile(2, 5, 2, rep8(8'h08), rep8(8'h10), 1'b1);
        lit_all(8'h40, 8'h40, 1'b0, 1'b0);
        ack();

        for (int e = 0; e < 8; e++) begin
            mix_a[e*8 +: 8] = 8'(e + 1);
            mix_b[e*8 +: 8] = (e < 4) ? 8'h10 : 8'(e - 3);
        end
        send_tile(1, 1, 1, mix_a, mix_b, 1'b1);
        chk("mix_r1", out_0, 32'h041A020A);
        chk("mix_r0", out_1, 32'h041A010A);
        ack();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fixed_matmul_acc.md
FIXED_MATMUL_ACC -- requirements
Module: fixed_matmul_acc

Interface
REQ-001 SHALL have parameter IN1_WIDTH, default 8: operand-1 element width, signed two's complement.
REQ-002 SHALL have parameter IN1_FRAC_WIDTH, default 4: operand-1 fractional bits.
REQ-003 SHALL have parameter IN2_WIDTH, default 8: operand-2 element width, signed.
REQ-004 SHALL have parameter IN2_FRAC_WIDTH, default 4: operand-2 fractional bits.
REQ-005 SHALL have parameter OUT_WIDTH, default 8: result element width, signed.
REQ-006 SHALL have parameter OUT_FRAC_WIDTH, default 4: result fractional bits; IN1_FRAC_WIDTH+IN2_FRAC_WIDTH-OUT_FRAC_WIDTH (SHIFT) >= 0 required.
REQ-007 SHALL have parameter IN1_PARALLELISM, default 2: operand-1 rows per beat.
REQ-008 SHALL have parameter IN2_PARALLELISM, default 2: operand-2 rows per beat.
REQ-009 SHALL have parameter IN_SIZE, default 4: elements per row per beat.
REQ-010 SHALL have parameter MAX_DEPTH, default 8: maximum beats accumulated per tile.
REQ-011 SHALL have parameter ROUND, default 1: 0 = truncate (floor), 1 = round-half-up.
REQ-012 SHALL have ports: clk input 1 clock; rst input 1 asynchronous active-low reset.
REQ-013 SHALL have ports: data_in1 input IN1_WIDTH x IN1_PARALLELISM*IN_SIZE; data_in1_valid input 1; data_in1_ready output 1.
REQ-014 SHALL have ports: data_in2 input IN2_WIDTH x IN2_PARALLELISM*IN_SIZE; data_in2_valid input 1; data_in2_ready output 1.
REQ-015 SHALL have port depth_cfg input clog2(MAX_DEPTH+1): beats per tile, sampled on first beat of a tile.
REQ-016 SHALL have ports: data_out output OUT_WIDTH x IN1_PARALLELISM*IN2_PARALLELISM; data_out_valid output 1; data_out_ready input 1; data_out_ovf output 1 (any lane saturated).

Function
REQ-017 SHALL compute lane [i*IN2_PARALLELISM+j] = sum over beats and k of data_in1[i*IN_SIZE+k]*data_in2[j*IN_SIZE+k] (i.e. A*B^T per tile).
REQ-018 SHALL use FSM states ACCUM, OUT; ACCUM after reset.
REQ-019 SHALL join inputs: data_in1_ready = ACCUM & data_in2_valid; data_in2_ready = ACCUM & data_in1_valid; beat accepted only when both valid in ACCUM.
REQ-020 SHALL latch effective depth on first beat: 0 -> 1, >MAX_DEPTH -> MAX_DEPTH; depth_cfg changes mid-tile ignored.
REQ-021 SHALL hold full-precision accumulators of IN1_WIDTH+IN2_WIDTH+clog2(IN_SIZE*MAX_DEPTH) bits, cleared at tile start; no internal wrap possible.
REQ-022 SHALL count accepted beats; on the beat completing effective depth, transition to OUT next cycle with data_out_valid=1 (latency 1 cycle from last accepted beat).
REQ-023 SHALL form result = (acc + (ROUND && SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT, then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-024 SHALL set data_out_ovf=1 with the result if any lane clipped; exact boundary values are not overflow.
REQ-025 SHALL hold data_out, data_out_ovf stable and readies low while OUT and data_out_ready=0.
REQ-026 SHALL on OUT & data_out_ready: drop data_out_valid, return to ACCUM next cycle; no beat accepted in that cycle; tile throughput = depth+1 cycles min.
REQ-027 SHALL ignore input valids/data in OUT (no accumulator change).

Reset
REQ-028 SHALL on rst=0 (asynchronous, any state, mid-tile included): state ACCUM, beat count 0, accumulators 0, data_out all 0, data_out_valid 0, data_out_ovf 0, both readies 0 while rst=0.
REQ-029 SHALL discard any partial tile on reset; first tile after release starts fresh.

Verification
REQ-030 SHALL cover: depth_cfg=1, all data_in1=0x10, data_in2=0x10 -> one cycle after beat, all lanes 0x40, ovf=0.
REQ-031 SHALL cover: depth_cfg=3, same data -> lanes 0x7F, ovf=1, valid after 3rd beat; data_in1=0xF0, data_in2=0x10, depth 2 -> 0x80, ovf=0.
REQ-032 SHALL cover: depth 1, data_in1=0x01, data_in2=0x02 -> ROUND=1 lanes 0x01; ROUND=0 lanes 0x00.
REQ-033 SHALL cover: data_out_ready low 5 cycles in OUT -> data_out stable, readies 0; only data_in1_valid high in ACCUM -> data_in1_ready 0, no accept.
REQ-034 SHALL cover: depth 3, rst low after 2 beats -> all outputs 0; new depth-1 tile of 0x10/0x10 -> 0x40, no residue.
REQ-035 SHALL cover: depth_cfg=0 -> treated as 1; depth_cfg=15 -> 8 beats; depth_cfg altered mid-tile -> no effect.
